// File: rtl/adder_sched.sv
// Two-requester round-robin scheduler in front of a registered carry-bypass adder.
// Optional lock chaining is enabled by defining ADDER_SCHED_LOCK_EN.
module adder_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req0_cin,
  input  logic             req1_cin,
`ifdef ADDER_SCHED_LOCK_EN
  input  logic             req0_lock,
  input  logic             req1_lock,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int BLK  = 4;
  localparam int NBLK = (WIDTH + BLK - 1) / BLK;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_id_q, rsp_id_d;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

`ifdef ADDER_SCHED_LOCK_EN
  localparam logic [2:0] LOCK_MAX = 3'd4;
  logic       lock_q, lock_d;
  logic [2:0] lock_cnt_q, lock_cnt_d;
  logic       lock_owner_q, lock_owner_d;
  logic       lock_in;
`endif

  // Ripple inside each block; a fully propagating block forwards its carry-in directly.
  always_comb begin : carry_bypass
    logic c;
    logic blk_c;
    logic p_all;
    logic p;
    add_sum = '0;
    c       = cin_q;
    blk_c   = 1'b0;
    p_all   = 1'b0;
    p       = 1'b0;
    for (int blk = 0; blk < NBLK; blk++) begin
      blk_c = c;
      p_all = 1'b1;
      for (int i = 0; i < BLK; i++) begin
        if (blk * BLK + i < WIDTH) begin
          p                    = a_q[blk*BLK+i] ^ b_q[blk*BLK+i];
          add_sum[blk*BLK+i]   = p ^ c;
          c                    = (a_q[blk*BLK+i] & b_q[blk*BLK+i]) | (p & c);
          p_all                = p_all & p;
        end
      end
      c = p_all ? blk_c : c;
    end
    add_cout = c;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_id_d   = rsp_id_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
`ifdef ADDER_SCHED_LOCK_EN
    lock_d       = lock_q;
    lock_cnt_d   = lock_cnt_q;
    lock_owner_d = lock_owner_q;
    lock_in      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Grants stay off while reset is held so no handshake can slip through.
        if (rst_n) begin
          gnt0 = req0_valid && (!req1_valid || !ptr_q);
          gnt1 = req1_valid && (!req0_valid || ptr_q);
        end
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          cin_d   = gnt1 ? req1_cin : req0_cin;
          id_d    = gnt1;
          state_d = EXEC;
`ifdef ADDER_SCHED_LOCK_EN
          lock_in      = gnt1 ? req1_lock : req0_lock;
          lock_d       = lock_in;
          lock_owner_d = gnt1;
          if (lock_in) begin
            lock_cnt_d = (lock_cnt_q != 3'd0 && lock_owner_q == gnt1) ? lock_cnt_q + 3'd1 : 3'd1;
          end else begin
            lock_cnt_d = 3'd0;
          end
`endif
        end
      end
      EXEC: begin
        rsp_sum_d  = add_sum;
        rsp_cout_d = add_cout;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
`ifdef ADDER_SCHED_LOCK_EN
          // A lock keeps the pointer home until the chain length hits its cap.
          if (lock_q && lock_cnt_q < LOCK_MAX) begin
            ptr_d = rsp_id_q;
          end else begin
            ptr_d = !rsp_id_q;
          end
          if (lock_cnt_q >= LOCK_MAX) begin
            lock_cnt_d = 3'd0;
          end
`else
          ptr_d = !rsp_id_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      id_q       <= 1'b0;
      ptr_q      <= 1'b0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_id_q   <= 1'b0;
`ifdef ADDER_SCHED_LOCK_EN
      lock_q       <= 1'b0;
      lock_cnt_q   <= 3'd0;
      lock_owner_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_id_q   <= rsp_id_d;
`ifdef ADDER_SCHED_LOCK_EN
      lock_q       <= lock_d;
      lock_cnt_q   <= lock_cnt_d;
      lock_owner_q <= lock_owner_d;
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_sum    = rsp_sum_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_adder_sched.sv
// Directed bench for adder_sched: cycle model plus expected-result queue, and
// fixed id sequences for arbitration (lock behaviour when ADDER_SCHED_LOCK_EN is set).
module tb_adder_sched;

  localparam int W = 32;

  typedef struct packed {
    logic         id;
    logic         cout;
    logic [W-1:0] sum;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_id;
`ifdef ADDER_SCHED_LOCK_EN
  logic         req0_lock, req1_lock;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];
  logic served[$];
  int   served_cyc[$];

  // Bench-side reference of the scheduler state
  int   m_state = 0;   // 0 idle, 1 exec, 2 resp
  logic m_ptr   = 1'b0;
  logic m_lock  = 1'b0;
  int   m_cnt   = 0;
  logic m_owner = 1'b0;

  always #5 clk = ~clk;

  adder_sched #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req0_cin  (req0_cin),
    .req1_cin  (req1_cin),
`ifdef ADDER_SCHED_LOCK_EN
    .req0_lock (req0_lock),
    .req1_lock (req1_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic c0, input logic v1, input logic [W-1:0] a1,
                               input logic [W-1:0] b1, input logic c1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
  endtask

  // Sample at the falling edge against the model, then step the model and the clock.
  task automatic tick();
    logic         e0, e1, lk;
    logic [W:0]   t;
    exp_t         e;
    @(negedge clk);
    if (!rst_n) begin
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_sum", rsp_sum, 0);
      checkOutput("rst_rsp_cout", rsp_cout, 0);
      checkOutput("rst_rsp_id", rsp_id, 0);
      checkOutput("rst_ready0", req0_ready, 0);
      checkOutput("rst_ready1", req1_ready, 0);
      m_state = 0; m_ptr = 1'b0; m_cnt = 0; m_lock = 1'b0; m_owner = 1'b0;
      sb.delete();
    end else begin
      e0 = (m_state == 0) && req0_valid && (!req1_valid || !m_ptr);
      e1 = (m_state == 0) && req1_valid && (!req0_valid || m_ptr);
      checkOutput("ready0", req0_ready, e0);
      checkOutput("ready1", req1_ready, e1);
      checkOutput("rsp_valid", rsp_valid, m_state == 2);
      if (m_state == 0 && (e0 || e1)) begin
        t = e1 ? ({1'b0, req1_a} + {1'b0, req1_b} + (W+1)'(req1_cin))
               : ({1'b0, req0_a} + {1'b0, req0_b} + (W+1)'(req0_cin));
        e.id = e1; e.cout = t[W]; e.sum = t[W-1:0];
        sb.push_back(e);
        lk = 1'b0;
`ifdef ADDER_SCHED_LOCK_EN
        lk = e1 ? req1_lock : req0_lock;
`endif
        m_lock = lk;
        if (lk) m_cnt = (m_cnt != 0 && m_owner == e1) ? m_cnt + 1 : 1;
        else    m_cnt = 0;
        m_owner = e1;
        m_state = 1;
      end else if (m_state == 1) begin
        m_state = 2;
      end else if (m_state == 2) begin
        if (sb.size() == 0) begin
          checkOutput("sb_empty", 1, 0);
        end else begin
          checkOutput("rsp_sum", rsp_sum, sb[0].sum);
          checkOutput("rsp_cout", rsp_cout, sb[0].cout);
          checkOutput("rsp_id", rsp_id, sb[0].id);
          if (rsp_ready) begin
            e = sb.pop_front();
            served.push_back(rsp_id);
            served_cyc.push_back(cyc);
            m_ptr = (m_lock && m_cnt < 4) ? e.id : !e.id;
            if (m_cnt >= 4) m_cnt = 0;
            m_state = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    rsp_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic checkIds(input string tag, input logic [5:0] exp_ids);
    for (int i = 0; i < 6; i++) begin
      checkOutput(tag, (served.size() > i) ? 64'(served[i]) : 64'hDEAD, 64'(exp_ids[i]));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
`ifdef ADDER_SCHED_LOCK_EN
    req0_lock = 1'b0; req1_lock = 1'b0;
`endif
    repeat (2) tick();
    rst_n = 1'b1;

    // All-ones plus one: carry runs the full width and lands in cout
    applyStimulus(1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, '0, '0, 0);
    tick();
    req0_valid = 1'b0;
    tick();
    checkOutput("t1_valid_n2", rsp_valid, 1);
    checkOutput("t1_sum", rsp_sum, 32'h0);
    checkOutput("t1_cout", rsp_cout, 1);
    checkOutput("t1_id", rsp_id, 0);
    tick();
    drain();

    // MSB overflow with carry-in
    applyStimulus(0, '0, '0, 0, 1, 32'h8000_0000, 32'h8000_0000, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    checkOutput("t2_sum", rsp_sum, 32'h1);
    checkOutput("t2_cout", rsp_cout, 1);
    checkOutput("t2_id", rsp_id, 1);
    tick();
    drain();

    // Backpressure: response must hold steady, no grants meanwhile
    applyStimulus(0, '0, '0, 0, 1, 32'h1234_5678, 32'h0F0F_0F0F, 1);
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_sum", rsp_sum, 32'h2143_6588);
      checkOutput("t3_hold_cout", rsp_cout, 0);
      checkOutput("t3_hold_r0", req0_ready, 0);
      checkOutput("t3_hold_r1", req1_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    applyStimulus(0, '0, '0, 0, 0, '0, '0, 0);
    drain();

    // Continuous contention alternates, one response every 3 cycles
    served.delete(); served_cyc.delete();
    applyStimulus(1, 32'd100, 32'd23, 0, 1, 32'hA5A5_0000, 32'h0000_5A5A, 1);
    repeat (20) tick();
    drain();
    checkIds("t4_id_seq", 6'b101010);
    for (int i = 1; i < 6; i++) begin
      checkOutput("t4_spacing",
                  (served_cyc.size() > i) ? 64'(served_cyc[i] - served_cyc[i-1]) : 64'hDEAD, 3);
    end

    // Mid-operation reset discards the transaction and resets the pointer
    applyStimulus(1, 32'd7, 32'd8, 0, 0, '0, '0, 0);
    tick();
    req0_valid = 1'b0;
    repeat (2) tick();
    applyStimulus(1, 32'd1, 32'd2, 0, 1, 32'd3, 32'd4, 0);
    tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    checkOutput("t5_gnt0", req0_ready, 1);
    checkOutput("t5_gnt1", req1_ready, 0);
    checkOutput("t5_no_rsp", rsp_valid, 0);
    repeat (4) tick();
    drain();

    // Lock chaining on requester 0 (plain alternation when the feature is absent)
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    served.delete(); served_cyc.delete();
`ifdef ADDER_SCHED_LOCK_EN
    req0_lock = 1'b1; req1_lock = 1'b0;
`endif
    applyStimulus(1, 32'd5, 32'd6, 1, 1, 32'd9, 32'd10, 0);
    repeat (20) tick();
    drain();
`ifdef ADDER_SCHED_LOCK_EN
    checkIds("t6_lock_seq", 6'b010000);
`else
    checkIds("t6_lock_seq", 6'b101010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
